// File: rtl/paddle_render_sequencer.sv
// Paddle render sequencer: per frame, issues clear/draw stage pulses for two paddles,
// waits on the renderer's done pulses with a per-stage timeout, and queues one extra request.
module paddle_render_sequencer #(
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = $clog2(TIMEOUT) + 1
) (
   input  logic clk,
   input  logic resetn,
   input  logic enable,
   input  logic frame_tick,
   input  logic moved1,
   input  logic moved2,
   input  logic done_clear1,
   input  logic done_draw1,
   input  logic done_clear2,
   input  logic done_draw2,
   input  logic err_clr,
   output logic pulse_clear1,
   output logic pulse_draw1,
   output logic pulse_clear2,
   output logic pulse_draw2,
   output logic busy,
   output logic frame_done,
   output logic overrun,
   output logic timeout_err
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_CLR1   = 4'd1,
      S_W_CLR1 = 4'd2,
      S_DRW1   = 4'd3,
      S_W_DRW1 = 4'd4,
      S_CLR2   = 4'd5,
      S_W_CLR2 = 4'd6,
      S_DRW2   = 4'd7,
      S_W_DRW2 = 4'd8,
      S_DONE   = 4'd9
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_WARN = CNT_W'(TIMEOUT - 2);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t             state_r, state_s;
   logic [CNT_W-1:0]   cnt_r, cnt_s;
   logic               pending_r, pending_s;
   logic               m1_r, m1_s;
   logic               m2_r, m2_s;
   logic               en_r;
   logic               overrun_r, timeout_err_r;
   logic               set_ov_s, set_to_s;
   logic               wait_s, done_sel_s;
   state_t             tgt_s;

   // Next-state, request queue and timeout decision
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      pending_s  = pending_r;
      m1_s       = m1_r;
      m2_s       = m2_r;
      set_ov_s   = 1'b0;
      set_to_s   = 1'b0;
      wait_s     = 1'b0;
      done_sel_s = 1'b0;
      tgt_s      = S_IDLE;
      if (enable) begin
         // A tick while busy is queued once; a second one is lost.
         if (state_r != S_IDLE && frame_tick) begin
            if (pending_r) begin
               set_ov_s = 1'b1;
            end else begin
               pending_s = 1'b1;
            end
         end else begin
            pending_s = pending_r;
         end
         case (state_r)
            S_IDLE: begin
               if (frame_tick || pending_r) begin
                  m1_s      = moved1;
                  m2_s      = moved2;
                  pending_s = frame_tick & pending_r;
                  state_s   = moved1 ? S_CLR1 : S_DRW1;
               end else begin
                  state_s = S_IDLE;
               end
            end
            S_CLR1:   begin cnt_s = {CNT_W{1'b0}}; state_s = S_W_CLR1; end
            S_DRW1:   begin cnt_s = {CNT_W{1'b0}}; state_s = S_W_DRW1; end
            S_CLR2:   begin cnt_s = {CNT_W{1'b0}}; state_s = S_W_CLR2; end
            S_DRW2:   begin cnt_s = {CNT_W{1'b0}}; state_s = S_W_DRW2; end
            S_W_CLR1: begin wait_s = 1'b1; done_sel_s = done_clear1; tgt_s = S_DRW1; end
            S_W_DRW1: begin wait_s = 1'b1; done_sel_s = done_draw1;  tgt_s = m2_r ? S_CLR2 : S_DRW2; end
            S_W_CLR2: begin wait_s = 1'b1; done_sel_s = done_clear2; tgt_s = S_DRW2; end
            S_W_DRW2: begin wait_s = 1'b1; done_sel_s = done_draw2;  tgt_s = S_DONE; end
            S_DONE:   state_s = S_IDLE;
            default:  state_s = S_IDLE;
         endcase
         // The flag rises as the counter reaches its last value; the advance follows one cycle later.
         if (wait_s) begin
            if (done_sel_s || cnt_r == CNT_LAST) begin
               state_s = tgt_s;
            end else begin
               cnt_s    = cnt_r + CNT_ONE;
               set_to_s = (cnt_r == CNT_WARN);
            end
         end else begin
            set_to_s = 1'b0;
         end
      end else begin
         state_s = state_r;
      end
   end

   // State, counter, queue and sticky flag registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r       <= S_IDLE;
         cnt_r         <= {CNT_W{1'b0}};
         pending_r     <= 1'b0;
         m1_r          <= 1'b0;
         m2_r          <= 1'b0;
         en_r          <= 1'b0;
         overrun_r     <= 1'b0;
         timeout_err_r <= 1'b0;
      end else begin
         state_r       <= state_s;
         cnt_r         <= cnt_s;
         pending_r     <= pending_s;
         m1_r          <= m1_s;
         m2_r          <= m2_s;
         en_r          <= enable;
         overrun_r     <= set_ov_s | (overrun_r & ~err_clr);
         timeout_err_r <= set_to_s | (timeout_err_r & ~err_clr);
      end
   end

   // en_r gates pulses so a frozen issue/done state never repeats its pulse
   assign pulse_clear1 = en_r & (state_r == S_CLR1);
   assign pulse_draw1  = en_r & (state_r == S_DRW1);
   assign pulse_clear2 = en_r & (state_r == S_CLR2);
   assign pulse_draw2  = en_r & (state_r == S_DRW2);
   assign frame_done   = en_r & (state_r == S_DONE);
   assign busy         = (state_r != S_IDLE);
   assign overrun      = overrun_r;
   assign timeout_err  = timeout_err_r;

endmodule

// File: tb/tb_paddle_render_sequencer.sv
// Bench for paddle_render_sequencer: directed frame tables, corner sequences and
// random stimulus compared every cycle against a stage-list reference model.
module tb_paddle_render_sequencer;

   localparam int TO = 8;

   logic clk = 1'b0;
   logic resetn, enable, frame_tick, moved1, moved2;
   logic done_clear1, done_draw1, done_clear2, done_draw2, err_clr;
   logic pulse_clear1, pulse_draw1, pulse_clear2, pulse_draw2;
   logic busy, frame_done, overrun, timeout_err;

   paddle_render_sequencer #(.TIMEOUT(TO)) dut (
      .clk(clk), .resetn(resetn), .enable(enable), .frame_tick(frame_tick),
      .moved1(moved1), .moved2(moved2),
      .done_clear1(done_clear1), .done_draw1(done_draw1),
      .done_clear2(done_clear2), .done_draw2(done_draw2),
      .err_clr(err_clr),
      .pulse_clear1(pulse_clear1), .pulse_draw1(pulse_draw1),
      .pulse_clear2(pulse_clear2), .pulse_draw2(pulse_draw2),
      .busy(busy), .frame_done(frame_done), .overrun(overrun), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: a frame is a list of stages (0 clr1, 1 drw1, 2 clr2, 3 drw2)
   int m_phase = 0;  // 0 idle, 1 issuing, 2 waiting, 3 done
   int m_stg[4];
   int m_n = 0, m_idx = 0, m_cnt = 0;
   bit m_pend = 0, m_ov = 0, m_to = 0, m_en = 0;

   function automatic bit done_of(input int s);
      case (s)
         0: return done_clear1;
         1: return done_draw1;
         2: return done_clear2;
         default: return done_draw2;
      endcase
   endfunction

   task automatic model_step();
      bit nov, nto;
      nov = 0; nto = 0;
      if (!resetn) begin
         m_phase = 0; m_pend = 0; m_ov = 0; m_to = 0; m_en = 0; m_cnt = 0;
         return;
      end
      if (enable) begin
         if (m_phase != 0 && frame_tick) begin
            if (m_pend) nov = 1; else m_pend = 1;
         end
         case (m_phase)
            0: if (frame_tick || m_pend) begin
                  m_n = 0;
                  if (moved1) begin m_stg[m_n] = 0; m_n++; end
                  m_stg[m_n] = 1; m_n++;
                  if (moved2) begin m_stg[m_n] = 2; m_n++; end
                  m_stg[m_n] = 3; m_n++;
                  m_pend = frame_tick && m_pend;
                  m_idx = 0;
                  m_phase = 1;
               end
            1: begin m_phase = 2; m_cnt = 0; end
            2: begin
                  if (done_of(m_stg[m_idx]) || m_cnt == TO - 1) begin
                     m_idx++;
                     m_phase = (m_idx == m_n) ? 3 : 1;
                  end else begin
                     m_cnt++;
                     if (m_cnt == TO - 1) nto = 1;
                  end
               end
            default: m_phase = 0;
         endcase
      end
      m_en = enable;
      if (err_clr) begin m_ov = 0; m_to = 0; end
      if (nov) m_ov = 1;
      if (nto) m_to = 1;
   endtask

   function automatic logic [7:0] model_out();
      logic [3:0] p;
      p = 4'd0;
      if (m_en && m_phase == 1) p[3 - m_stg[m_idx]] = 1'b1;
      return {p, m_phase != 0, m_en && m_phase == 3, m_ov, m_to};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check("cycle_outputs", {24'd0, pulse_clear1, pulse_draw1, pulse_clear2, pulse_draw2,
                              busy, frame_done, overrun, timeout_err}, int'(model_out()));
   endtask

   task automatic idle_inputs();
      frame_tick = 0; err_clr = 0;
      done_clear1 = 0; done_draw1 = 0; done_clear2 = 0; done_draw2 = 0;
   endtask

   task automatic set_done(input int s);
      done_clear1 = (s == 0); done_draw1 = (s == 1);
      done_clear2 = (s == 2); done_draw2 = (s == 3);
   endtask

   function automatic logic [3:0] pulses();
      return {pulse_clear1, pulse_draw1, pulse_clear2, pulse_draw2};
   endfunction

   typedef struct {
      bit m1, m2;
      int dly;
      int e_c1, e_d1, e_c2, e_d2, e_fd, e_to, e_b0, e_b1;
   } vec_t;

   int obs[8];
   string nm[8] = '{"first_clear1", "first_draw1", "first_clear2", "first_draw2",
                    "first_frame_done", "first_timeout_err", "first_busy", "last_busy"};

   // One frame from a tick: records first pulse cycles; renderer answers dly cycles after each pulse (0 = never)
   task automatic run_frame(input bit a, input bit b, input int dly);
      int pc, ps;
      pc = -100; ps = -1;
      for (int k = 0; k < 8; k++) obs[k] = -1;
      moved1 = a; moved2 = b; frame_tick = 1;
      step();
      frame_tick = 0;
      for (int c = 1; c < 40; c++) begin
         for (int k = 0; k < 4; k++) begin
            if (pulses()[3 - k]) begin
               if (obs[k] < 0) obs[k] = c;
               pc = c; ps = k;
            end
         end
         if (frame_done && obs[4] < 0) obs[4] = c;
         if (timeout_err && obs[5] < 0) obs[5] = c;
         if (busy && obs[6] < 0) obs[6] = c;
         if (busy) obs[7] = c;
         set_done((dly > 0 && c == pc + dly) ? ps : -1);
         step();
      end
      idle_inputs();
   endtask

   vec_t tbl[5];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int pc, ps, nfd, fd1, fd2, st2, late;
      vec_t v;
      tbl[0] = '{1, 1, 3,  1,  5,  9, 13, 17, -1, 1, 17};
      tbl[1] = '{0, 0, 3, -1,  1, -1,  5,  9, -1, 1,  9};
      tbl[2] = '{1, 0, 3,  1,  5, -1,  9, 13, -1, 1, 13};
      tbl[3] = '{0, 1, 3, -1,  1,  5,  9, 13, -1, 1, 13};
      tbl[4] = '{1, 0, 0,  1, 10, -1, 19, 28,  9, 1, 28};

      resetn = 0; enable = 1; moved1 = 0; moved2 = 0;
      idle_inputs();
      step(); step();
      check("reset_outputs", {pulses(), busy, frame_done, overrun, timeout_err}, 0);
      resetn = 1;
      step();

      // Directed frames
      foreach (tbl[i]) begin
         v = tbl[i];
         err_clr = 1; step(); err_clr = 0; step();
         run_frame(v.m1, v.m2, v.dly);
         check(nm[0], obs[0], v.e_c1); check(nm[1], obs[1], v.e_d1);
         check(nm[2], obs[2], v.e_c2); check(nm[3], obs[3], v.e_d2);
         check(nm[4], obs[4], v.e_fd); check(nm[5], obs[5], v.e_to);
         check(nm[6], obs[6], v.e_b0); check(nm[7], obs[7], v.e_b1);
      end
      check("timeout_err_held", timeout_err, 1);
      err_clr = 1; step(); err_clr = 0;
      check("timeout_err_cleared", timeout_err, 0);

      // Two ticks during one frame: one queued, one lost
      moved1 = 1; moved2 = 1; frame_tick = 1; step(); frame_tick = 0;
      pc = -100; ps = -1; nfd = 0; fd1 = -1; fd2 = -1; st2 = -1;
      for (int c = 1; c < 50; c++) begin
         for (int k = 0; k < 4; k++) if (pulses()[3 - k]) begin pc = c; ps = k; end
         if (frame_done) begin
            nfd++;
            if (fd1 < 0) fd1 = c; else fd2 = c;
         end
         if (fd1 >= 0 && st2 < 0 && pulse_clear1) st2 = c;
         if (c == 6) check("overrun_before_second", overrun, 0);
         if (c == 7) check("overrun_after_second", overrun, 1);
         frame_tick = (c == 3 || c == 6);
         set_done(c == pc + 3 ? ps : -1);
         step();
      end
      idle_inputs();
      check("ovr_frame_done_count", nfd, 2);
      check("ovr_first_done", fd1, 17);
      check("ovr_second_start", st2, 19);
      check("ovr_second_done", fd2, 35);

      // Reset in W_CLR2 with done asserted; overrun still set going in
      moved1 = 1; moved2 = 1; frame_tick = 1; step(); frame_tick = 0;
      pc = -100; ps = -1; late = 0;
      for (int c = 1; c < 40; c++) begin
         for (int k = 0; k < 4; k++) if (pulses()[3 - k]) begin pc = c; ps = k; end
         if (c >= 12 && (pulses() != 4'd0 || frame_done)) late++;
         if (c == 12 || c == 13)
            check("reset_mid_outputs", {pulses(), busy, frame_done, overrun, timeout_err}, 0);
         resetn = !(c == 11 || c == 12);
         set_done((c == 11 || c == 12) ? 2 : (c == pc + 3 ? ps : -1));
         step();
      end
      idle_inputs(); resetn = 1;
      check("reset_late_pulses", late, 0);

      // Enable low for 5 cycles in W_DRW1, done_draw1 during the freeze
      moved1 = 0; moved2 = 0; frame_tick = 1; step(); frame_tick = 0;
      obs[0] = -1; obs[1] = 0; obs[2] = -1; obs[3] = -1;
      for (int c = 1; c < 30; c++) begin
         if (c >= 2 && c <= 9 && (pulses() != 4'd0 || !busy)) obs[1]++;
         if (pulse_draw2 && obs[2] < 0) obs[2] = c;
         if (frame_done && obs[3] < 0) obs[3] = c;
         enable = !(c >= 3 && c <= 7);
         done_draw1 = (c == 4 || c == 9);
         done_draw2 = (c == 13);
         step();
      end
      idle_inputs(); enable = 1;
      check("freeze_bad_cycles", obs[1], 0);
      check("freeze_draw2", obs[2], 10);
      check("freeze_frame_done", obs[3], 14);

      // Random stimulus against the model
      for (int i = 0; i < 3000; i++) begin
         resetn      = ($urandom_range(0, 199) != 0);
         enable      = ($urandom_range(0, 9) != 0);
         frame_tick  = ($urandom_range(0, 14) == 0);
         moved1      = $urandom_range(0, 1);
         moved2      = $urandom_range(0, 1);
         done_clear1 = ($urandom_range(0, 5) == 0);
         done_draw1  = ($urandom_range(0, 5) == 0);
         done_clear2 = ($urandom_range(0, 5) == 0);
         done_draw2  = ($urandom_range(0, 5) == 0);
         err_clr     = ($urandom_range(0, 29) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/paddle_render_sequencer.md
PADDLE_RENDER_SEQUENCER -- requirements
Module: paddle_render_sequencer

Interface
REQ-001 Parameter: TIMEOUT, default 1024; wait-state cycle limit per drawing stage, minimum 2.
REQ-002 Parameter: CNT_W, default $clog2(TIMEOUT)+1; timeout counter width.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  high = run; low = freeze all state.
REQ-006 frame_tick  input  1  one-cycle frame-start request.
REQ-007 moved1 / moved2  input  1 each  paddle 1 / paddle 2 position changed this frame.
REQ-008 done_clear1, done_draw1, done_clear2, done_draw2  input  1 each  stage-complete pulses from the paddle renderer.
REQ-009 err_clr  input  1  clears sticky error flags.
REQ-010 pulse_clear1, pulse_draw1, pulse_clear2, pulse_draw2  output  1 each  one-cycle stage-start pulses to the paddle renderer.
REQ-011 busy  output  1  high while a frame sequence is in progress.
REQ-012 frame_done  output  1  one-cycle pulse when a frame sequence completes.
REQ-013 overrun  output  1  sticky: a frame request was lost.
REQ-014 timeout_err  output  1  sticky: a stage timed out.

Function
REQ-015 FSM states: IDLE, CLR1, W_CLR1, DRW1, W_DRW1, CLR2, W_CLR2, DRW2, W_DRW2, DONE.
REQ-016 All outputs shall be registered, or decoded from registered state only; no combinational input-to-output path.
REQ-017 IDLE: if enable and (frame_tick or pending), latch moved1/moved2 into m1/m2, clear pending, and go to CLR1 if m1 else DRW1.
REQ-018 Issue states CLR1/DRW1/CLR2/DRW2 shall assert only their matching pulse for exactly one cycle, zero the timeout counter, and go to the matching wait state.
REQ-019 Latency: frame_tick sampled in IDLE at edge k shall produce the first pulse during cycle k+1.
REQ-020 Wait states advance on their own done input: W_CLR1 -> DRW1; W_DRW1 -> CLR2 if m2 else DRW2; W_CLR2 -> DRW2; W_DRW2 -> DONE.
REQ-021 Done inputs other than the current wait state's shall be ignored; a done that arrives in an issue state shall be ignored.
REQ-022 In a wait state without done, the counter increments; when it equals TIMEOUT-1, the FSM shall set timeout_err and advance as if done had arrived.
REQ-023 DONE: frame_done high for one cycle, then IDLE; busy is high in every state except IDLE.
REQ-024 At most one of the four stage pulses and frame_done shall be high in any cycle.
REQ-025 frame_tick while busy (or in the same cycle as a start): if pending is clear, set it; if already set, set overrun (one-deep queue).
REQ-026 A pending request shall start the next frame directly from IDLE, one cycle after DONE.
REQ-027 enable low: state, counter, pending, m1/m2 held; all pulses and frame_done forced 0; frame_tick ignored; done inputs ignored.
REQ-028 err_clr clears overrun and timeout_err; if a set and err_clr coincide, the set wins.
REQ-029 m1/m2 are sampled only at frame start; changes to moved1/moved2 mid-frame shall have no effect.

Reset
REQ-030 resetn low at a clock edge: state IDLE, counter 0, pending 0, m1=m2=0, all outputs 0, including the sticky flags.
REQ-031 Reset mid-sequence shall abort it with no further pulse or frame_done; done inputs during reset shall be ignored.

Verification
REQ-032 moved1=moved2=1, tick at cycle 0, each done 3 cycles after its pulse -> pulses clear1@1, draw1@5, clear2@9, draw2@13; frame_done@17; busy 1..17.
REQ-033 moved1=0, moved2=0 -> only draw1 and draw2 pulses; clear pulses never high.
REQ-034 TIMEOUT=8, done_clear1 never returned -> timeout_err=1 on the 8th W_CLR1 cycle, draw1 pulse next cycle, sequence completes; err_clr -> timeout_err=0.
REQ-035 Two ticks during one busy frame -> pending=1, overrun=1; second frame starts the cycle after frame_done; exactly 2 frame_done pulses total.
REQ-036 enable dropped for 5 cycles in W_DRW1 -> state held, no pulses, done_draw1 ignored; resume and continue waiting.
REQ-037 resetn asserted in W_CLR2 -> all outputs 0 next cycle; no draw2 pulse or frame_done after release until a new tick.
